// File: rtl/input_process_uart_if.sv
// Byte-in / word-out bundle for the UART receive word assembler.
// The master side feeds received bytes and the message setup, and the slave side returns words.
interface input_process_uart_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  MSG_LEN_IN;
    logic        PARITY_IN;
    logic [15:0] DATA;
    logic        ENA;
    logic        LAST;
    logic        TIMEOUT;
    logic        BUSY;

    modport master (
        output rx_data, rx_valid, MSG_LEN_IN, PARITY_IN,
        input  DATA, ENA, LAST, TIMEOUT, BUSY
    );

    modport slave (
        input  rx_data, rx_valid, MSG_LEN_IN, PARITY_IN,
        output DATA, ENA, LAST, TIMEOUT, BUSY
    );
endinterface

// File: rtl/input_process_uart.sv
// UART receive-side word assembler.
// It packs MSB-first byte pairs into 16-bit words and tracks the word index within a message.
// Messages have a programmable length, and an odd byte count is supported.
// A message that stalls between bytes is dropped after TIMEOUT_CYCLES clock cycles.
module input_process_uart #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input_process_uart_if.slave  bus
);
    typedef enum logic {WAIT_MSB, WAIT_LSB} state_t;

    // Terminal value of the idle counter: TIMEOUT fires on the idle cycle that would reach TIMEOUT_CYCLES.
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q,  wcnt_d;
    logic [7:0]  len_q,   len_d;
    logic        par_q,   par_d;
    logic [7:0]  msb_q,   msb_d;
    logic [23:0] tcnt_q,  tcnt_d;
    logic [15:0] data_q,  data_d;
    logic        ena_q,   ena_d;
    logic        last_q,  last_d;
    logic        tout_q,  tout_d;
    logic        busy_q,  busy_d;

    assign bus.DATA    = data_q;
    assign bus.ENA     = ena_q;
    assign bus.LAST    = last_q;
    assign bus.TIMEOUT = tout_q;
    assign bus.BUSY    = busy_q;

    // Compute the next state: byte assembly, message position and the inter-byte timeout.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        par_d   = par_q;
        msb_d   = msb_q;
        tcnt_d  = tcnt_q;
        data_d  = data_q;
        ena_d   = 1'b0;
        last_d  = 1'b0;
        tout_d  = 1'b0;
        busy_d  = busy_q;

        if (bus.rx_valid) begin
            // A byte always beats the timeout, even on the terminal count.
            tcnt_d = '0;
            if (state_q == WAIT_MSB) begin
                msb_d = bus.rx_data;
                // The message shape is frozen at its first byte.
                if (wcnt_q == 8'd0) begin
                    len_d = bus.MSG_LEN_IN;
                    par_d = bus.PARITY_IN;
                end
                // A length of 0 wraps to a last index of 255, which gives 256 words.
                if (par_d && (wcnt_q == 8'(len_d - 8'd1))) begin
                    data_d  = {bus.rx_data, 8'h00};
                    ena_d   = 1'b1;
                    last_d  = 1'b1;
                    wcnt_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = WAIT_LSB;
                    busy_d  = 1'b1;
                end
            end else begin
                data_d  = {msb_q, bus.rx_data};
                ena_d   = 1'b1;
                state_d = WAIT_MSB;
                if (!par_q && (wcnt_q == 8'(len_q - 8'd1))) begin
                    last_d = 1'b1;
                    wcnt_d = '0;
                    busy_d = 1'b0;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
        end else if (!busy_q) begin
            tcnt_d = '0;
        end else if (TO_EN) begin
            if (tcnt_q == TO_LAST) begin
                // Drop the partial message and resync on the next byte. DATA is left untouched.
                tout_d  = 1'b1;
                wcnt_d  = '0;
                state_d = WAIT_MSB;
                tcnt_d  = '0;
                busy_d  = 1'b0;
            end else begin
                tcnt_d = tcnt_q + 24'd1;
            end
        end
    end

    // Register all state and outputs. Reset silently discards any partial message.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= WAIT_MSB;
            wcnt_q  <= '0;
            len_q   <= '0;
            par_q   <= 1'b0;
            msb_q   <= '0;
            tcnt_q  <= '0;
            data_q  <= '0;
            ena_q   <= 1'b0;
            last_q  <= 1'b0;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            par_q   <= par_d;
            msb_q   <= msb_d;
            tcnt_q  <= tcnt_d;
            data_q  <= data_d;
            ena_q   <= ena_d;
            last_q  <= last_d;
            tout_q  <= tout_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_input_process_uart.sv
// Self-checking bench for input_process_uart.
// A byte-counting message model predicts every output on every cycle.
module tb_input_process_uart;
    localparam int TO = 100;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    input_process_uart_if bus();

    input_process_uart #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // 100 MHz-style free-running clock.
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Message model: bytes seen in the current message, the byte total it needs, and idle cycles since the last byte.
    int          m_cnt, m_total, m_idle;
    logic [7:0]  m_prev;
    logic [15:0] e_data;
    logic        e_ena, e_last, e_to, e_busy;
    logic [19:0] obs, exp_v;   // {ENA, LAST, TIMEOUT, BUSY, DATA}

    function automatic void model_reset();
        m_cnt  = 0;
        m_total = 0;
        m_idle = 0;
        m_prev = '0;
        e_data = '0;
        e_ena  = 1'b0;
        e_last = 1'b0;
        e_to   = 1'b0;
        e_busy = 1'b0;
    endfunction

    // Drive one cycle, advance the model over that edge, and sample the outputs 1 time unit later.
    task automatic step(input logic v, input logic [7:0] b);
        logic [7:0] len;
        logic       par;
        bus.rx_valid = v;
        bus.rx_data  = b;
        len = bus.MSG_LEN_IN;
        par = bus.PARITY_IN;
        @(posedge CLK);
        e_ena  = 1'b0;
        e_last = 1'b0;
        e_to   = 1'b0;
        if (v) begin
            if (m_cnt == 0)
                m_total = ((len == 8'd0) ? 256 : int'(len)) * 2 - int'(par);
            m_cnt++;
            m_idle = 0;
            if (m_cnt % 2 == 0) begin
                e_data = {m_prev, b};
                e_ena  = 1'b1;
            end else if (m_cnt == m_total) begin
                e_data = {b, 8'h00};
                e_ena  = 1'b1;
            end
            if (m_cnt == m_total) begin
                e_last = 1'b1;
                m_cnt  = 0;
            end
            m_prev = b;
        end else if (m_cnt > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                e_to   = 1'b1;
                m_cnt  = 0;
                m_idle = 0;
            end
        end
        e_busy = (m_cnt > 0);
        #1;
        obs   = {bus.ENA, bus.LAST, bus.TIMEOUT, bus.BUSY, bus.DATA};
        exp_v = {e_ena, e_last, e_to, e_busy, e_data};
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        bus.rx_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        model_reset();
        obs = {bus.ENA, bus.LAST, bus.TIMEOUT, bus.BUSY, bus.DATA};
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (obs !== 20'h0) begin
            $display("FAIL reset_state got %h want %h", obs, 20'h0);
            failures++;
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'($urandom));
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL reset_idle cyc%0d got %h want %h", i, obs, exp_v);
                failures++;
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] bs [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        bus.MSG_LEN_IN = 8'd2;
        bus.PARITY_IN  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bs[i]);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL basic byte%0d got %h want %h", i, obs, exp_v);
                failures++;
            end
        end
        checks++;
        if ({bus.ENA, bus.LAST, bus.BUSY, bus.DATA} !== {3'b110, 16'hC3D4}) begin
            $display("FAIL basic_last got %b%b%b %h want 110 c3d4", bus.ENA, bus.LAST, bus.BUSY, bus.DATA);
            failures++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'($urandom));
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL basic_hold cyc%0d got %h want %h", i, obs, exp_v);
                failures++;
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] bs [3] = '{8'h11, 8'h22, 8'h33};
        bus.MSG_LEN_IN = 8'd2;
        bus.PARITY_IN  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, bs[i]);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL parity byte%0d got %h want %h", i, obs, exp_v);
                failures++;
            end
            if (i < 2) begin
                step(1'b0, 8'($urandom));
                checks++;
                if (obs !== exp_v) begin
                    $display("FAIL parity_gap%0d got %h want %h", i, obs, exp_v);
                    failures++;
                end
            end
        end
        checks++;
        if ({bus.ENA, bus.LAST, bus.DATA} !== {2'b11, 16'h3300}) begin
            $display("FAIL parity_last got %b%b %h want 11 3300", bus.ENA, bus.LAST, bus.DATA);
            failures++;
        end
        step(1'b0, 8'h00);
    endtask

    task automatic test_timeout();
        int         touts;
        logic [7:0] tail [4] = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};
        bus.MSG_LEN_IN = 8'd3;
        bus.PARITY_IN  = 1'b0;
        touts = 0;
        step(1'b1, 8'h55);
        for (int i = 0; i < TO + 3; i++) begin
            step(1'b0, 8'($urandom));
            touts += int'(bus.TIMEOUT);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL timeout_gap cyc%0d got %h want %h", i, obs, exp_v);
                failures++;
            end
        end
        checks++;
        if (touts !== 1) begin
            $display("FAIL timeout_count got %0d want 1", touts);
            failures++;
        end
        step(1'b1, 8'hAA);
        step(1'b1, 8'hBB);
        checks++;
        if ({bus.ENA, bus.LAST, bus.DATA} !== {2'b10, 16'hAABB}) begin
            $display("FAIL timeout_resync got %b%b %h want 10 aabb", bus.ENA, bus.LAST, bus.DATA);
            failures++;
        end
        touts = 0;
        for (int i = 0; i < TO - 1; i++) begin
            step(1'b0, 8'($urandom));
            touts += int'(bus.TIMEOUT);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, tail[i]);
            touts += int'(bus.TIMEOUT);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL timeout_tail byte%0d got %h want %h", i, obs, exp_v);
                failures++;
            end
        end
        checks++;
        if (touts !== 0 || {bus.LAST, bus.DATA} !== {1'b1, 16'hEEFF}) begin
            $display("FAIL timeout_edge got to=%0d last=%b %h want to=0 last=1 eeff", touts, bus.LAST, bus.DATA);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        int touts;
        bus.MSG_LEN_IN = 8'd2;
        bus.PARITY_IN  = 1'b0;
        step(1'b1, 8'h77);
        apply_reset();
        checks++;
        if (obs !== 20'h0) begin
            $display("FAIL reset_mid got %h want %h", obs, 20'h0);
            failures++;
        end
        touts = 0;
        for (int i = 0; i < TO + 10; i++) begin
            step(1'b0, 8'($urandom));
            touts += int'(bus.TIMEOUT);
        end
        checks++;
        if (touts !== 0 || obs !== exp_v) begin
            $display("FAIL reset_quiet got to=%0d %h want to=0 %h", touts, obs, exp_v);
            failures++;
        end
        bus.MSG_LEN_IN = 8'd1;
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        checks++;
        if ({bus.ENA, bus.LAST, bus.BUSY, bus.DATA} !== {3'b110, 16'h0102} || obs !== exp_v) begin
            $display("FAIL reset_after got %h want %h", obs, {4'b1100, 16'h0102});
            failures++;
        end
    endtask

    task automatic test_len_latch();
        int lasts;
        lasts = 0;
        bus.MSG_LEN_IN = 8'd3;
        bus.PARITY_IN  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                bus.MSG_LEN_IN = 8'd1;
                bus.PARITY_IN  = 1'b1;
            end
            step(1'b1, 8'($urandom));
            lasts += int'(bus.LAST);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL len_latch byte%0d got %h want %h", i, obs, exp_v);
                failures++;
            end
        end
        checks++;
        if (lasts !== 1 || bus.LAST !== 1'b1) begin
            $display("FAIL len_latch_last got lasts=%0d final=%b want 1 1", lasts, bus.LAST);
            failures++;
        end
        bus.PARITY_IN = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bs [3] = '{8'h9F, 8'hA0, 8'hA1};
        int enas, lasts;
        bus.MSG_LEN_IN = 8'd1;
        bus.PARITY_IN  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, bs[i]);
            checks++;
            if (obs !== exp_v || {bus.ENA, bus.LAST, bus.BUSY, bus.DATA} !== {3'b110, bs[i], 8'h00}) begin
                $display("FAIL b2b_single byte%0d got %h want %h", i, obs, exp_v);
                failures++;
            end
        end
        bus.MSG_LEN_IN = 8'd0;
        bus.PARITY_IN  = 1'b0;
        enas = 0;
        lasts = 0;
        for (int i = 0; i < 512; i++) begin
            step(1'b1, 8'($urandom));
            enas  += int'(bus.ENA);
            lasts += int'(bus.LAST);
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL b2b_long byte%0d got %h want %h", i, obs, exp_v);
                failures++;
            end
        end
        checks++;
        if (enas !== 256 || lasts !== 1 || bus.LAST !== 1'b1) begin
            $display("FAIL b2b_long_count got ena=%0d last=%0d want 256 1", enas, lasts);
            failures++;
        end
        step(1'b0, 8'h00);
    endtask

    // Random stream with shifting message setup, short gaps and occasional long gaps that may hit the timeout.
    task automatic test_random();
        int gap;
        for (int n = 0; n < 400; n++) begin
            bus.MSG_LEN_IN = 8'($urandom_range(1, 4));
            bus.PARITY_IN  = 1'($urandom);
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 3, TO + 3))
                                              : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 8'($urandom));
                checks++;
                if (obs !== exp_v) begin
                    $display("FAIL random_gap n%0d g%0d got %h want %h", n, g, obs, exp_v);
                    failures++;
                end
            end
            step(1'b1, 8'($urandom));
            checks++;
            if (obs !== exp_v) begin
                $display("FAIL random_byte n%0d got %h want %h", n, obs, exp_v);
                failures++;
            end
        end
    endtask

    initial begin
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.MSG_LEN_IN = 8'd1;
        bus.PARITY_IN  = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_parity();
        test_timeout();
        test_reset_mid();
        test_len_latch();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
